// File: rtl/optest_sweeper.sv
// Exhaustive operand sweeper/checker: issues every (a, b) pair to two operator
// implementations, pairs their in-order results and stops on the first mismatch.
module optest_sweeper #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RWIDTH = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic [WIDTH-1:0]    op_a,
  output logic [WIDTH-1:0]    op_b,
  output logic                op_valid,
  input  logic                op_ready,
  input  logic                res_valid,
  input  logic [RWIDTH-1:0]   res1,
  input  logic [RWIDTH-1:0]   res2,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [WIDTH-1:0]    err_a,
  output logic [WIDTH-1:0]    err_b,
  output logic [RWIDTH-1:0]   err_r1,
  output logic [RWIDTH-1:0]   err_r2,
  output logic [2*WIDTH:0]    checked
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;
  logic             first_mm;
  logic             last_pair;

  // Handshake decode and next FIFO occupancy; results arriving on an empty FIFO are dropped.
  always_comb begin
    push       = op_valid & op_ready;
    pop        = res_valid & (count != '0);
    first_mm   = pop & (res1 != res2) & ~error;
    last_pair  = (op_a == '1) & (op_b == '1);
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // Operand-tag storage; only the pointers need reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_a[wr_ptr] <= op_a;
      fifo_b[wr_ptr] <= op_b;
    end
  end

  // Sweep FSM, operand counters, FIFO pointers and result checking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_a    <= '0;
      err_b    <= '0;
      err_r1   <= '0;
      err_r2   <= '0;
      checked  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        checked <= checked + NW'(1);
      end
      if (first_mm) begin
        error  <= 1'b1;
        err_a  <= fifo_a[rd_ptr];
        err_b  <= fifo_b[rd_ptr];
        err_r1 <= res1;
        err_r2 <= res2;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_a    <= '0;
            err_b    <= '0;
            err_r1   <= '0;
            err_r2   <= '0;
            checked  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
          end
        end

        RUN: begin
          if (push) begin
            op_b <= op_b + WIDTH'(1);
            if (op_b == '1) begin
              op_a <= op_a + WIDTH'(1);
            end
          end
          // Valid is registered from next occupancy so held operands never lose valid.
          if (first_mm || (push && last_pair)) begin
            op_valid <= 1'b0;
            if (count_next == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            op_valid <= (count_next < CW'(DEPTH));
          end
        end

        DRAIN: begin
          op_valid <= 1'b0;
          if (count_next == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_optest_sweeper.sv
// Self-checking bench for optest_sweeper: bench-side operator models, in-order
// result responder and a transaction-level model of the sweep.
module tb_optest_sweeper;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned NP = 1 << (2 * W);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          op_ready;
  logic          res_valid;
  logic [RW-1:0] res1;
  logic [RW-1:0] res2;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_valid;
  logic          busy;
  logic          done;
  logic          error;
  logic [W-1:0]  err_a;
  logic [W-1:0]  err_b;
  logic [RW-1:0] err_r1;
  logic [RW-1:0] err_r2;
  logic [2*W:0]  checked;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-sweep observations for the caller.
  int gaps;
  int max_out;
  bit saw_stall;
  bit hit_rst;

  optest_sweeper #(.WIDTH(W), .RWIDTH(RW), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .start(start),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .res_valid(res_valid), .res1(res1), .res2(res2),
    .busy(busy), .done(done), .error(error),
    .err_a(err_a), .err_b(err_b), .err_r1(err_r1), .err_r2(err_r2),
    .checked(checked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Implementation 1: product; implementation 2 optionally corrupted at (9,5).
  function automatic logic [RW-1:0] impl1(input logic [W-1:0] a, input logic [W-1:0] b);
    return RW'(a) * RW'(b);
  endfunction

  function automatic logic [RW-1:0] impl2(input bit inj, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [RW-1:0] r;
    r = impl1(a, b);
    if (inj && a == W'(9) && b == W'(5)) r = r ^ RW'(1);
    return r;
  endfunction

  // mode 0: ready=1, latency 1; mode 1: random ready, latency 1..D; mode 2: ready=1, latency D+3.
  task automatic run_sweep(input bit inj, input int mode, input bit rst_a4, input bit start_mid);
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           qdue[$];
    int k = 0, pops = 0, outst = 0, cur_out, e = 0, last_due = 0, last_pop_e = -1;
    int lat, due, budget = 5000;
    bit stop_iss = 0, merr = 0, prev_stall = 0, did_mid = 0, timed_out = 0;
    logic [W-1:0]  pa = '0, pb = '0, ea = '0, eb = '0, ha, hb;
    logic [RW-1:0] er1 = '0, er2 = '0, r1, r2;

    gaps = 0; max_out = 0; saw_stall = 0; hit_rst = 0;
    op_ready = 1'b1; res_valid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_op_valid", 64'(op_valid), 64'(1));
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_done", 64'(done), 64'(0));
    chk("start_error", 64'(error), 64'(0));
    chk("start_checked", 64'(checked), 64'(0));

    while (!done) begin
      if (budget == 0) begin
        chk("sweep_timeout", 64'(0), 64'(1));
        timed_out = 1;
        break;
      end
      budget--;
      cur_out = outst;
      chk("checked_track", 64'(checked), 64'(pops));
      if (stop_iss) chk("no_issue_after_stop", 64'(op_valid), 64'(0));
      if (prev_stall && !stop_iss) begin
        chk("hold_valid", 64'(op_valid), 64'(1));
        chk("hold_a", 64'(op_a), 64'(pa));
        chk("hold_b", 64'(op_b), 64'(pb));
      end
      if (rst_a4 && op_valid && op_a == W'(4)) begin
        hit_rst = 1;
        break;
      end
      start = 1'b0;
      if (start_mid && k >= 50 && !did_mid) begin
        start = 1'b1;
        did_mid = 1;
      end

      // Return the oldest outstanding result once its latency has elapsed.
      res_valid = 1'b0; res1 = '0; res2 = '0;
      if (qdue.size() > 0 && qdue[0] <= e + 1) begin
        void'(qdue.pop_front());
        ha = qa.pop_front();
        hb = qb.pop_front();
        r1 = impl1(ha, hb);
        r2 = impl2(inj, ha, hb);
        res_valid = 1'b1; res1 = r1; res2 = r2;
        pops++; outst--; last_pop_e = e + 1;
        if (r1 != r2 && !merr) begin
          merr = 1; stop_iss = 1;
          ea = ha; eb = hb; er1 = r1; er2 = r2;
        end
      end

      op_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 0 && !stop_iss && !op_valid) gaps++;
      if (!op_valid && cur_out == int'(D)) saw_stall = 1;
      if (op_valid && op_ready) begin
        chk("xfer_a", 64'(op_a), 64'(k >> W));
        chk("xfer_b", 64'(op_b), 64'(k % (1 << W)));
        lat = (mode == 1) ? int'($urandom_range(1, D)) : (mode == 2) ? int'(D) + 3 : 1;
        due = e + 1 + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        qa.push_back(op_a); qb.push_back(op_b); qdue.push_back(due);
        k++; outst++;
        if (k == int'(NP)) stop_iss = 1;
      end
      if (outst > max_out) max_out = outst;
      chk("occupancy", 64'(outst <= int'(D)), 64'(1));
      prev_stall = op_valid && !op_ready;
      pa = op_a; pb = op_b;
      @(negedge clock);
      e++;
    end

    start = 1'b0;
    res_valid = 1'b0;
    if (!hit_rst && !timed_out) begin
      chk("done_timing", 64'(e), 64'(last_pop_e));
      chk("end_busy", 64'(busy), 64'(0));
      chk("end_op_valid", 64'(op_valid), 64'(0));
      chk("end_error", 64'(error), 64'(merr));
      chk("end_checked", 64'(checked), 64'(k));
      if (merr) begin
        chk("end_err_a", 64'(err_a), 64'(ea));
        chk("end_err_b", 64'(err_b), 64'(eb));
        chk("end_err_r1", 64'(err_r1), 64'(er1));
        chk("end_err_r2", 64'(err_r2), 64'(er2));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op_a"}, 64'(op_a), 64'(0));
    chk({tag, "_op_b"}, 64'(op_b), 64'(0));
    chk({tag, "_op_valid"}, 64'(op_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_error"}, 64'(error), 64'(0));
    chk({tag, "_err_ab"}, 64'({err_a, err_b}), 64'(0));
    chk({tag, "_err_r"}, 64'({err_r1, err_r2}), 64'(0));
    chk({tag, "_checked"}, 64'(checked), 64'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_ready = 1'b0;
    res_valid = 1'b0; res1 = '0; res2 = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Clean sweep at full rate.
    run_sweep(0, 0, 0, 0);
    chk("t1_checked", 64'(checked), 64'(256));
    chk("t1_error", 64'(error), 64'(0));
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_no_gaps", 64'(gaps), 64'(0));

    // Stray result with nothing outstanding is ignored.
    res_valid = 1'b1; res1 = 8'h01; res2 = 8'h02;
    @(negedge clock);
    res_valid = 1'b0;
    @(negedge clock);
    chk("stray_checked", 64'(checked), 64'(256));
    chk("stray_error", 64'(error), 64'(0));
    chk("stray_done", 64'(done), 64'(1));

    // Single corrupted pair at (9,5): index 149, so 150 compares plus in-flight.
    run_sweep(1, 0, 0, 0);
    chk("t2_error", 64'(error), 64'(1));
    chk("t2_err_a", 64'(err_a), 64'(9));
    chk("t2_err_b", 64'(err_b), 64'(5));
    chk("t2_err_r1", 64'(err_r1), 64'(8'h2d));
    chk("t2_err_r2", 64'(err_r2), 64'(8'h2c));
    chk("t2_checked_bound", 64'(int'(checked) >= 150 && int'(checked) <= 150 + int'(D)), 64'(1));

    // Restart from DONE clears error; random stalls; start pulse mid-run ignored.
    run_sweep(0, 1, 0, 1);
    chk("t3_checked", 64'(checked), 64'(256));
    chk("t3_error", 64'(error), 64'(0));

    // Slow results: issue must stall at D outstanding.
    run_sweep(0, 2, 0, 0);
    chk("t4_checked", 64'(checked), 64'(256));
    chk("t4_saw_stall", 64'(saw_stall), 64'(1));
    chk("t4_max_out", 64'(max_out), 64'(D));

    // Asynchronous reset mid-run, then a fresh sweep from a=b=0.
    run_sweep(0, 0, 1, 0);
    chk("t5_reached_a4", 64'(hit_rst), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    run_sweep(0, 0, 0, 0);
    chk("t5_checked", 64'(checked), 64'(256));
    chk("t5_error", 64'(error), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
